busca_controle: RTL and testbench
=================================

Name: busca_controle

Overview:
- Instruction-fetch and control stage directly upstream of the decode stage.
- Holds the PC and a word-addressed instruction memory, and sequences the 4-bit `estado` bus that gates every stage of the multi-cycle datapath.
- Presents `instrucao` to the decoder, then applies the branch/sequential PC update reported back by execute.
- Loadable at runtime through a write port; halts on a null instruction, an out-of-range PC or a misaligned branch.

Parameters:
- MEM_PALAVRAS, 64, instruction memory depth in 32-bit words.
- END_BITS, 6, word-address width; must equal clog2(MEM_PALAVRAS).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- carga_en  in  1  instruction-memory write enable.
- carga_end  in  END_BITS  word address for memory load.
- carga_dado  in  32  word to load.
- desvio_tomado  in  1  execute stage: branch taken; sampled in ESCRITA.
- desvio_offset  in  32  branch offset magnitude in bytes.
- desvio_negativo  in  1  1 = subtract offset, 0 = add.
- instrucao  out  32  fetched instruction (registered).
- pc  out  32  byte address of the instruction currently in flight.
- estado  out  4  stage state bus.
- parado  out  1  halted.
- erro  out  1  halted due to fault (range/alignment).
- instr_executadas  out  32  count of retired instructions.

Behaviour:
- Reset (synchronous, active-high, dominates everything else):
  - pc=0, instrucao=0, estado=4'b0000, parado=0, erro=0, instr_executadas=0.
  - Memory contents are retained.
- States (encoding = estado value): BUSCA 0000 -> DECODIFICA 0001 -> EXECUTA 0010 -> MEMORIA 0011 -> ESCRITA 0100 -> BUSCA; PARADO 1111 is terminal until reset.
- BUSCA:
  - If carga_en=1, stay in BUSCA (load stall) and issue no fetch.
  - Else if pc[31:2] >= MEM_PALAVRAS, go to PARADO with erro=1.
  - Else read w = mem[pc[END_BITS+1:2]] combinationally.
    - If w == 32'h0: go to PARADO, erro=0, instrucao unchanged.
    - Otherwise: instrucao<=w and estado<=0001 on the same edge. The decoder therefore sees estado=0001 with a valid instrucao for one full cycle.
- DECODIFICA, EXECUTA, MEMORIA: one cycle each, unconditional advance; pc and instrucao held.
- ESCRITA (one cycle): sample the desvio_* inputs.
  - If desvio_tomado=0: alvo = pc+4.
  - If desvio_tomado=1: alvo = pc+offset when desvio_negativo=0, pc-offset when desvio_negativo=1; 32-bit arithmetic.
  - Fault: if desvio_negativo=1 and offset > pc (underflow), or alvo[1:0] != 0, go to PARADO with erro=1. pc is left unchanged and instr_executadas is still incremented.
  - Normal: pc<=alvo, instr_executadas<=instr_executadas+1 (wraps at 2^32), estado<=BUSCA.
- PARADO: parado=1; all state frozen; carga_en writes are still accepted; only reset exits.
- Memory write:
  - Any cycle with carga_en=1 (including during reset) writes mem[carga_end]<=carga_dado on the clock edge.
  - A fetch in the same cycle is suppressed by the stall rule, so there is no read/write collision.
- carga_en asserted outside BUSCA: the write happens, and the FSM continues undisturbed.
- Outputs are all registered; parado = (estado==1111).

Optional Feature:
- PASSO_A_PASSO_EN adds input `avancar` (1 bit).
- Defined: BUSCA fetches only in a cycle where avancar=1, in addition to the other BUSCA conditions. Otherwise BUSCA holds, giving single-instruction stepping. The remaining stages are unaffected.
- Undefined: port absent; BUSCA fetches whenever not stalled by load.

Test Plan:
- Load mem[0]=32'h00500093, mem[1]=32'h00000000; release reset -> estado sequence 0,1,2,3,4,0,F; instrucao=32'h00500093 during 0001; pc 0 then 4; instr_executadas=1; parado=1, erro=0.
- Load 3 nonzero words, desvio_tomado=0 -> pc visits 0,4,8,12; each estado=0001 cycle carries the matching word; instr_executadas=3; halts on the zero word at mem[3].
- At pc=8 in ESCRITA drive desvio_tomado=1, desvio_negativo=1, offset=8 -> next pc=0. Then offset=16 negative at pc=8 -> PARADO, erro=1, pc stays 8.
- Branch offset=6 positive at pc=0 -> alvo=6, misaligned -> PARADO, erro=1. With MEM_PALAVRAS=64, a branch to pc=256 -> next BUSCA goes to PARADO, erro=1.
- Hold carga_en=1 for 3 cycles in BUSCA -> estado stays 0000, no fetch; drop carga_en -> fetch of the newly written word. Assert reset mid-EXECUTA -> next edge pc=0, estado=0000, counter=0, memory intact.
- With PASSO_A_PASSO_EN: avancar=0 for 5 cycles -> estado=0000 held. One-cycle avancar pulse -> exactly one full 0->4->0 pass.

Source files
------------

// File: rtl/busca_controle_if.sv
// Signal bundle between busca_controle and its environment (loader, execute, decoder).
// With PASSO_A_PASSO_EN defined the bundle also carries the avancar single-step input.
interface busca_controle_if #(
    parameter int END_BITS = 6
);
    logic                carga_en;
    logic [END_BITS-1:0] carga_end;
    logic [31:0]         carga_dado;
    logic                desvio_tomado;
    logic [31:0]         desvio_offset;
    logic                desvio_negativo;
`ifdef PASSO_A_PASSO_EN
    logic                avancar;
`endif
    logic [31:0]         instrucao;
    logic [31:0]         pc;
    logic [3:0]          estado;
    logic                parado;
    logic                erro;
    logic [31:0]         instr_executadas;

    modport master (
`ifdef PASSO_A_PASSO_EN
        output avancar,
`endif
        output carga_en, carga_end, carga_dado,
        output desvio_tomado, desvio_offset, desvio_negativo,
        input  instrucao, pc, estado, parado, erro, instr_executadas
    );

    modport slave (
`ifdef PASSO_A_PASSO_EN
        input  avancar,
`endif
        input  carga_en, carga_end, carga_dado,
        input  desvio_tomado, desvio_offset, desvio_negativo,
        output instrucao, pc, estado, parado, erro, instr_executadas
    );
endinterface

// File: rtl/busca_controle.sv
// Fetch/control stage: PC, loadable instruction memory and the 5-stage estado sequencer.
// Optional macro PASSO_A_PASSO_EN gates each fetch with the avancar input (single-step).
module busca_controle #(
    parameter int MEM_PALAVRAS = 64,
    parameter int END_BITS     = 6
) (
    input logic             clk,
    input logic             reset,
    busca_controle_if.slave bus
);
    typedef enum logic [3:0] {
        BUSCA      = 4'b0000,
        DECODIFICA = 4'b0001,
        EXECUTA    = 4'b0010,
        MEMORIA    = 4'b0011,
        ESCRITA    = 4'b0100,
        PARADO     = 4'b1111
    } estado_t;

    localparam logic [29:0] LIMITE = 30'(MEM_PALAVRAS);

    logic [31:0] mem [MEM_PALAVRAS];

    estado_t     estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instrucao_q, instrucao_d;
    logic [31:0] contador_q, contador_d;
    logic        erro_q, erro_d;
    logic        passo_ok;
    logic [31:0] palavra;
    logic [31:0] alvo;
    logic        falha_desvio;

`ifdef PASSO_A_PASSO_EN
    assign passo_ok = bus.avancar;
`else
    assign passo_ok = 1'b1;
`endif

    // The write port has no reset so a program loaded during reset survives it.
    always_ff @(posedge clk) begin
        if (bus.carga_en) begin
            mem[bus.carga_end] <= bus.carga_dado;
        end
    end

    assign palavra = mem[pc_q[END_BITS+1:2]];

    always_comb begin
        alvo         = pc_q + 32'd4;
        falha_desvio = 1'b0;
        if (bus.desvio_tomado) begin
            if (bus.desvio_negativo) begin
                alvo         = pc_q - bus.desvio_offset;
                falha_desvio = (bus.desvio_offset > pc_q);
            end else begin
                alvo = pc_q + bus.desvio_offset;
            end
        end
        if (alvo[1:0] != 2'b00) begin
            falha_desvio = 1'b1;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        pc_d        = pc_q;
        instrucao_d = instrucao_q;
        contador_d  = contador_q;
        erro_d      = erro_q;
        case (estado_q)
            BUSCA: begin
                // A load in progress stalls the fetch, so reads never collide with writes.
                if (!bus.carga_en && passo_ok) begin
                    if (pc_q[31:2] >= LIMITE) begin
                        estado_d = PARADO;
                        erro_d   = 1'b1;
                    end else if (palavra == 32'h0) begin
                        estado_d = PARADO;
                    end else begin
                        instrucao_d = palavra;
                        estado_d    = DECODIFICA;
                    end
                end
            end
            DECODIFICA: estado_d = EXECUTA;
            EXECUTA:    estado_d = MEMORIA;
            MEMORIA:    estado_d = ESCRITA;
            ESCRITA: begin
                contador_d = contador_q + 32'd1;
                if (falha_desvio) begin
                    estado_d = PARADO;
                    erro_d   = 1'b1;
                end else begin
                    pc_d     = alvo;
                    estado_d = BUSCA;
                end
            end
            PARADO:  estado_d = PARADO;
            default: estado_d = PARADO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= BUSCA;
            pc_q        <= 32'h0;
            instrucao_q <= 32'h0;
            contador_q  <= 32'h0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            pc_q        <= pc_d;
            instrucao_q <= instrucao_d;
            contador_q  <= contador_d;
            erro_q      <= erro_d;
        end
    end

    assign bus.instrucao        = instrucao_q;
    assign bus.pc               = pc_q;
    assign bus.estado           = estado_q;
    assign bus.parado           = (estado_q == PARADO);
    assign bus.erro             = erro_q;
    assign bus.instr_executadas = contador_q;
endmodule

// File: tb/tb_busca_controle.sv
// Bench for busca_controle: instruction-level reference model checked every cycle,
// plus directed programs with literal expectations on the final architectural state.
module tb_busca_controle;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    busca_controle_if #(.END_BITS(6)) bus ();
    busca_controle #(.MEM_PALAVRAS(64), .END_BITS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic avancar_tb = 1'b1;
`ifdef PASSO_A_PASSO_EN
    assign bus.avancar = avancar_tb;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_chk++;
        if (atual !== esperado)
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
        else
            n_pass++;
    endtask

    // Reference model: stage index 0..4 plus a halted flag, memory as a plain array.
    logic [31:0] m_mem [64];
    logic [31:0] m_pc, m_instr, m_cnt;
    int          m_fase;
    bit          m_halt, m_err;
    bit          chk_en = 1'b0;

    task automatic modelo_passo();
        longint alvo;
        int     idx;
        if (reset) begin
            m_pc = 0; m_instr = 0; m_cnt = 0; m_fase = 0; m_halt = 0; m_err = 0;
            chk_en = 1'b1;
        end else if (!m_halt) begin
            if (m_fase == 0) begin
                if (!bus.carga_en && avancar_tb) begin
                    idx = int'(m_pc >> 2);
                    if (m_pc / 4 >= 64) begin
                        m_halt = 1; m_err = 1;
                    end else if (m_mem[idx] == 32'h0) begin
                        m_halt = 1;
                    end else begin
                        m_instr = m_mem[idx];
                        m_fase  = 1;
                    end
                end
            end else if (m_fase < 4) begin
                m_fase++;
            end else begin
                m_cnt++;
                if (!bus.desvio_tomado)
                    alvo = longint'({32'b0, m_pc}) + 4;
                else if (bus.desvio_negativo)
                    alvo = longint'({32'b0, m_pc}) - longint'({32'b0, bus.desvio_offset});
                else
                    alvo = longint'({32'b0, m_pc}) + longint'({32'b0, bus.desvio_offset});
                if (alvo < 0 || (alvo % 4) != 0) begin
                    m_halt = 1; m_err = 1;
                end else begin
                    m_pc   = alvo[31:0];
                    m_fase = 0;
                end
                $display("retire #%0d instr=%h alvo=%0d halt=%0d erro=%0d", m_cnt, m_instr, alvo, m_halt, m_err);
            end
        end
        if (bus.carga_en) m_mem[bus.carga_end] = bus.carga_dado;
    endtask

    always @(posedge clk) modelo_passo();

    always @(negedge clk) begin
        if (chk_en) begin
            check("estado", 32'(bus.estado), m_halt ? 32'hF : 32'(m_fase));
            check("pc", bus.pc, m_pc);
            check("instrucao", bus.instrucao, m_instr);
            check("parado", 32'(bus.parado), 32'(m_halt));
            check("erro", 32'(bus.erro), 32'(m_err));
            check("instr_executadas", bus.instr_executadas, m_cnt);
        end
    end

    // Branch script: consumed in order when the DUT sits in ESCRITA at the listed pc.
    logic [31:0] br_pc [4];
    logic [31:0] br_off [4];
    bit          br_neg [4];
    int          br_n, br_idx;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic carrega(input int a, input logic [31:0] d);
        bus.carga_en = 1'b1; bus.carga_end = 6'(a); bus.carga_dado = d;
        tick();
        bus.carga_en = 1'b0;
    endtask

    task automatic desvios();
        bus.desvio_tomado = 1'b0; bus.desvio_negativo = 1'b0; bus.desvio_offset = 32'h0;
        if (bus.estado == 4'h4 && br_idx < br_n && bus.pc == br_pc[br_idx]) begin
            bus.desvio_tomado   = 1'b1;
            bus.desvio_offset   = br_off[br_idx];
            bus.desvio_negativo = br_neg[br_idx];
            br_idx++;
        end
    endtask

    task automatic roda_ate_parar(input int limite);
        bit ok = 1'b0;
        for (int i = 0; i < limite && !ok; i++) begin
            desvios();
            tick();
            if (bus.estado == 4'hF) ok = 1'b1;
        end
        bus.desvio_tomado = 1'b0;
        check("parou_no_prazo", 32'(ok), 32'd1);
    endtask

    task automatic espera(input logic [31:0] pc_alvo, input logic [3:0] est, input int limite);
        bit ok = 1'b0;
        for (int i = 0; i < limite && !ok; i++) begin
            desvios();
            tick();
            if (bus.pc == pc_alvo && bus.estado == est) ok = 1'b1;
        end
        bus.desvio_tomado = 1'b0;
        check("chegou_no_prazo", 32'(ok), 32'd1);
    endtask

    task automatic inicia(input int nbr);
        reset = 1'b1; br_n = nbr; br_idx = 0;
    endtask

    initial begin
        reset = 1'b1;
        bus.carga_en = 1'b0; bus.carga_end = '0; bus.carga_dado = '0;
        bus.desvio_tomado = 1'b0; bus.desvio_offset = '0; bus.desvio_negativo = 1'b0;
        br_n = 0; br_idx = 0;

        // Single instruction followed by a null word.
        inicia(0);
        carrega(0, 32'h00500093);
        carrega(1, 32'h00000000);
        check("reset_pc", bus.pc, 32'd0);
        check("reset_estado", 32'(bus.estado), 32'd0);
        check("reset_instrucao", bus.instrucao, 32'd0);
        check("reset_cnt", bus.instr_executadas, 32'd0);
        check("reset_parado", 32'(bus.parado), 32'd0);
        reset = 1'b0;
        roda_ate_parar(40);
        check("t1_pc", bus.pc, 32'd4);
        check("t1_cnt", bus.instr_executadas, 32'd1);
        check("t1_erro", 32'(bus.erro), 32'd0);
        check("t1_instr", bus.instrucao, 32'h00500093);

        // Three sequential words, halt on zero at mem[3].
        inicia(0);
        carrega(0, 32'h11111111); carrega(1, 32'h22222222);
        carrega(2, 32'h33333333); carrega(3, 32'h0);
        reset = 1'b0;
        roda_ate_parar(60);
        check("t2_pc", bus.pc, 32'd12);
        check("t2_cnt", bus.instr_executadas, 32'd3);
        check("t2_erro", 32'(bus.erro), 32'd0);
        check("t2_instr", bus.instrucao, 32'h33333333);

        // Backward branch to 0, then a backward branch that underflows.
        inicia(2);
        br_pc[0] = 8; br_off[0] = 8;  br_neg[0] = 1;
        br_pc[1] = 8; br_off[1] = 16; br_neg[1] = 1;
        carrega(3, 32'h44444444);
        reset = 1'b0;
        roda_ate_parar(100);
        check("t3_pc", bus.pc, 32'd8);
        check("t3_cnt", bus.instr_executadas, 32'd6);
        check("t3_erro", 32'(bus.erro), 32'd1);

        // Misaligned forward branch.
        inicia(1);
        br_pc[0] = 0; br_off[0] = 6; br_neg[0] = 0;
        tick();
        reset = 1'b0;
        roda_ate_parar(40);
        check("t4a_pc", bus.pc, 32'd0);
        check("t4a_cnt", bus.instr_executadas, 32'd1);
        check("t4a_erro", 32'(bus.erro), 32'd1);

        // Branch just past the end of memory.
        inicia(1);
        br_pc[0] = 0; br_off[0] = 256; br_neg[0] = 0;
        tick();
        reset = 1'b0;
        roda_ate_parar(40);
        check("t4b_pc", bus.pc, 32'd256);
        check("t4b_cnt", bus.instr_executadas, 32'd1);
        check("t4b_erro", 32'(bus.erro), 32'd1);

        // Load stall in BUSCA, reset mid-EXECUTA, write outside BUSCA.
        inicia(0);
        carrega(1, 32'h55555555); carrega(2, 32'h66666666); carrega(3, 32'h12345678);
        reset = 1'b0;
        bus.carga_en = 1'b1; bus.carga_end = 6'd0; bus.carga_dado = 32'hAAAA0001;
        repeat (3) begin
            tick();
            check("stall_estado", 32'(bus.estado), 32'd0);
        end
        bus.carga_en = 1'b0;
        tick();
        check("stall_fetch_estado", 32'(bus.estado), 32'd1);
        check("stall_fetch_instr", bus.instrucao, 32'hAAAA0001);
        espera(32'd8, 4'h2, 40);
        reset = 1'b1;
        tick();
        check("rst_mid_pc", bus.pc, 32'd0);
        check("rst_mid_estado", 32'(bus.estado), 32'd0);
        check("rst_mid_cnt", bus.instr_executadas, 32'd0);
        reset = 1'b0;
        tick();
        check("mem_retida", bus.instrucao, 32'hAAAA0001);
        carrega(3, 32'h0);
        check("carga_fora_busca", 32'(bus.estado), 32'd2);
        roda_ate_parar(60);
        check("t5_pc", bus.pc, 32'd12);
        check("t5_cnt", bus.instr_executadas, 32'd3);

`ifdef PASSO_A_PASSO_EN
        // Single-step: fetch only on an avancar pulse.
        inicia(0);
        carrega(0, 32'h77777777); carrega(1, 32'h88888888);
        avancar_tb = 1'b0;
        reset = 1'b0;
        repeat (5) begin
            tick();
            check("passo_espera", 32'(bus.estado), 32'd0);
        end
        avancar_tb = 1'b1;
        tick();
        avancar_tb = 1'b0;
        check("passo_busca", 32'(bus.estado), 32'd1);
        repeat (4) tick();
        check("passo_volta", 32'(bus.estado), 32'd0);
        check("passo_pc", bus.pc, 32'd4);
        repeat (3) tick();
        check("passo_segura", 32'(bus.estado), 32'd0);
        avancar_tb = 1'b1;
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
